// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
//   I2C target (slave) with a 7-bit address, byte-wide write and read paths.
//   SCL/SDA are synchronised into clk_sys-style domain `clk`; all bus timing
//   is derived from edges of the synchronised lines, so clk must run at
//   least 8x faster than SCL.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   scl_in    in   SCL wire level (asynchronous)
//   sda_in    in   SDA wire level (asynchronous)
//   sda_oe    out  1 = pull SDA low, 0 = release (open drain)
//   rx_data   out  last byte written by the controller
//   rx_valid  out  one-clk pulse when rx_data updates
//   tx_data   in   byte returned on the next read byte
//   tx_req    out  one-clk pulse requesting tx_data for the next read byte
//   busy      out  high from START until STOP
//   addr_hit  out  high while addressed (until STOP, repeated START or NACK)
//
// States
//   IDLE      | bus free or not yet seen a START since reset
//   ADDR      | shifting in address byte (7-bit address + R/W)
//   ADDR_ACK  | driving ACK for our address (8th fall .. 9th fall)
//   WR_DATA   | shifting in a write data byte
//   WR_ACK    | driving ACK for a received data byte
//   RD_DATA   | shifting out a read byte, MSB first
//   RD_ACK    | released SDA, sampling controller ACK/NACK at 9th rise
//   WAIT_STOP | not addressed or NACKed; ignore bus until STOP/START
// ---------------------------------------------------------------------------
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       addr_hit
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_DATA   = 3'd3,
        WR_ACK    = 3'd4,
        RD_DATA   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    state_t state_q, state_d;

    // [0] first sync stage, [1] synchronised level, [2] one-clk delayed copy
    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;

    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;
    logic       addr_hit_q, addr_hit_d;
    logic       rw_q, rw_d;
    // Set at the 9th rise of an ACK slot so the following fall closes the slot.
    logic       phase_q, phase_d;

    logic       scl_s, scl_p, sda_s, sda_p;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       last_bit, addr_match;
    logic [7:0] byte_in;

    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl_in};
        sda_sync_d = {sda_sync_q[1:0], sda_in};
    end

    assign scl_s = scl_sync_q[1];
    assign scl_p = scl_sync_q[2];
    assign sda_s = sda_sync_q[1];
    assign sda_p = sda_sync_q[2];

    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & sda_p & ~sda_s;
    assign stop_det  = scl_s & ~sda_p & sda_s;

    assign byte_in    = {shift_q[6:0], sda_s};
    assign last_bit   = (cnt_q == 3'd7);
    assign addr_match = (byte_in[7:1] == DEV_ADDR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; STOP beats START beats any bit-level event.
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = ADDR;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise && last_bit) begin
                        state_d = addr_match ? ADDR_ACK : WAIT_STOP;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall && phase_q) begin
                        state_d = rw_q ? RD_DATA : WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (scl_rise && last_bit) begin
                        state_d = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall && phase_q) begin
                        state_d = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_rise && last_bit) begin
                        state_d = RD_ACK;
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_d = WAIT_STOP;
                    end else if (scl_fall && phase_q) begin
                        state_d = RD_DATA;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and output logic. sda_oe only moves on a detected SCL fall,
    // except for the release forced by START/STOP.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        addr_hit_d = addr_hit_q;
        rw_d       = rw_q;
        phase_d    = phase_q;

        if (stop_det) begin
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            addr_hit_d = 1'b0;
            cnt_d      = 3'd0;
            phase_d    = 1'b0;
        end else if (start_det) begin
            sda_oe_d   = 1'b0;
            busy_d     = 1'b1;
            addr_hit_d = 1'b0;
            cnt_d      = 3'd0;
            phase_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (last_bit && addr_match) begin
                            addr_hit_d = 1'b1;
                            rw_d       = byte_in[0];
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (scl_rise) begin
                        phase_d = 1'b1;
                        if (state_q == ADDR_ACK && rw_q) begin
                            tx_req_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            cnt_d   = 3'd0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                shift_d  = tx_data;
                                sda_oe_d = ~tx_data[7];
                            end else begin
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (last_bit) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            addr_hit_d = 1'b0;
                            sda_oe_d   = 1'b0;
                        end else begin
                            tx_req_d = 1'b1;
                            phase_d  = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            phase_d  = 1'b0;
                            cnt_d    = 3'd0;
                            shift_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                        end
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            addr_hit_q <= 1'b0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            addr_hit_q <= addr_hit_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;
    assign addr_hit = addr_hit_q;

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, meaning the 7-bit target address answered on the bus.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk; clk frequency >= 8x SCL frequency.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port scl_in  input  1  SCL wire level, asynchronous to clk.
REQ-005 SHALL have port sda_in  input  1  SDA wire level, asynchronous to clk.
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-007 SHALL have port rx_data  output  8  last byte written by the controller.
REQ-008 SHALL have port rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-009 SHALL have port tx_data  input  8  byte returned on the next read byte.
REQ-010 SHALL have port tx_req  output  1  one-clk pulse requesting tx_data for the next read byte.
REQ-011 SHALL have port busy  output  1  high from START detect until STOP detect.
REQ-012 SHALL have port addr_hit  output  1  high while addressed, until STOP, repeated START or NACK.

Function
REQ-013 SHALL pass scl_in and sda_in through 2-flop synchronizers; edge and START/STOP detection SHALL use the synchronized values and their 1-clk delayed copies.
REQ-014 SHALL detect START as synced SDA 1->0 while synced SCL = 1, and STOP as synced SDA 0->1 while synced SCL = 1.
REQ-015 SHALL sample SDA on each synced SCL rising edge, MSB first, with a 3-bit bit counter that restarts at 0 every byte.
REQ-016 SHALL change sda_oe only on the clk cycle after a synced SCL falling edge is detected, never while SCL is high.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-018 IDLE -> ADDR on START; ADDR collects 8 bits, bits[7:1] address and bit0 R/W (1 = read).
REQ-019 On the 8th rise in ADDR: match -> ADDR_ACK with addr_hit = 1; mismatch -> WAIT_STOP with sda_oe held 0.
REQ-020 ADDR_ACK SHALL drive sda_oe = 1 from the 8th SCL fall to the 9th SCL fall, then enter WR_DATA (write) or RD_DATA (read).
REQ-021 WR_DATA SHALL, on the 8th rise, load rx_data and pulse rx_valid for one clk, then ACK in WR_ACK exactly as REQ-020 and return to WR_DATA.
REQ-022 Read: tx_req SHALL pulse on the 9th SCL rise of the address ACK or of an RD_ACK that samples SDA = 0; tx_data SHALL be latched into the shift register on the following SCL fall.
REQ-023 RD_DATA SHALL drive sda_oe = ~shift[7] after each SCL fall (bits 7..0) and release sda_oe on the 8th fall; RD_ACK samples the controller's ACK at the 9th rise.
REQ-024 RD_ACK sampling SDA = 1 (NACK) SHALL go to WAIT_STOP with sda_oe = 0 and addr_hit = 0.
REQ-025 START in any non-IDLE state (repeated START) SHALL go to ADDR, reset the bit counter and release sda_oe on the same clk.
REQ-026 STOP in any state SHALL go to IDLE, release sda_oe and clear busy and addr_hit on the same clk.
REQ-027 rx_valid and tx_req SHALL never both be high and never stay high for more than one clk.
REQ-028 The 8th rise in ADDR or WR_DATA SHALL take effect on that clk; a START/STOP on the same clk SHALL take priority and discard the partial byte.

Reset
REQ-029 rst_n = 0 SHALL immediately force IDLE, sda_oe = 0, rx_data = 8'h00, rx_valid = 0, tx_req = 0, busy = 0, addr_hit = 0, bit counter = 0, synchronizer flops = 1.
REQ-030 Reset asserted mid-transfer SHALL release SDA at once; after rst_n deasserts the block SHALL ignore bus activity until the next START.

Verification
REQ-031 Write: START, 0xA0, 0x3C, STOP -> ACK on bits 9 and 18, rx_data = 8'h3C with a single rx_valid pulse, busy 0 after STOP.
REQ-032 Address miss: START, 0xA2, 0x55, STOP -> sda_oe stays 0 throughout, no rx_valid, addr_hit stays 0.
REQ-033 Read: START, 0xA1, tx_data = 8'h96, controller NACK, STOP -> one tx_req, SDA carries 1001_0110, then WAIT_STOP and IDLE.
REQ-034 Multi-byte read: controller ACKs the first byte of tx_data 8'h12 then 8'h34 -> two tx_req pulses, bytes 0x12 and 0x34 on SDA in order.
REQ-035 Repeated START: write 0xA0, 0x01, repeated START, 0xA1 -> rx_data = 8'h01, address re-ACKed, tx_req issued.
REQ-036 rst_n pulsed low during the ACK bit of a write -> sda_oe drops on the same clk, all outputs at reset values, no ACK until a fresh START.
